// File: rtl/vocoder_mix_engine_pkg.sv
// Shared constants and FSM state type for the vocoder channel mixer.
package vocoder_mix_engine_pkg;

  localparam int N_FILTERS       = 16;
  localparam int MIX_N_CHANNELS  = N_FILTERS;
  localparam int MIX_IN_WIDTH    = 32;
  localparam int MIX_OUT_WIDTH   = 24;
  localparam int MIX_SHIFT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT
  } mix_state_t;

endpackage

// File: rtl/vocoder_mix_engine_sat_clamp.sv
// Combinational signed clamp of an IN_W value into the OUT_W two's-complement range.
module sat_clamp #(
  parameter int IN_W  = 66,
  parameter int OUT_W = 24
) (
  input  logic [IN_W-1:0]  in_dat,
  output logic [OUT_W-1:0] out_dat
);

  logic [IN_W-OUT_W:0] top_bits;
  logic                fits;

  // The value fits when every bit above the output sign bit matches it.
  assign top_bits = in_dat[IN_W-1:OUT_W-1];
  assign fits     = (top_bits == '0) || (top_bits == '1);

  always_comb begin
    out_dat = in_dat[OUT_W-1:0];
    if (!fits) begin
      out_dat = in_dat[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/vocoder_mix_engine.sv
// Time-multiplexed carrier*envelope mixer: one channel per cycle, result N_CHANNELS+2 cycles after
// acceptance; busy_out blocks new frames (dropped ones pulse overrun_out). VOCODER_MIX_SATURATE_EN clamps output.
module vocoder_mix_engine
  import vocoder_mix_engine_pkg::*;
#(
  parameter int N_CHANNELS  = MIX_N_CHANNELS,
  parameter int IN_WIDTH    = MIX_IN_WIDTH,
  parameter int OUT_WIDTH   = MIX_OUT_WIDTH,
  parameter int SHIFT_WIDTH = MIX_SHIFT_WIDTH
) (
  input  logic                           clk_in,
  input  logic                           n_rst_in,
  input  logic                           valid_in,
  input  logic [N_CHANNELS*IN_WIDTH-1:0] carrier_in,
  input  logic [N_CHANNELS*IN_WIDTH-1:0] envelope_in,
  input  logic [N_CHANNELS-1:0]          channel_en_in,
  input  logic [SHIFT_WIDTH-1:0]         shift_in,
  output logic [OUT_WIDTH-1:0]           mixed_out,
  output logic                           valid_out,
  output logic                           busy_out,
  output logic                           overrun_out
);

  localparam int PROD_W    = 2 * IN_WIDTH;
  localparam int ACC_WIDTH = PROD_W + $clog2(N_CHANNELS);
  localparam int IDX_W     = $clog2(N_CHANNELS);
  localparam int ARR_W     = N_CHANNELS * IN_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHANNELS - 1);

  mix_state_t                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [ARR_W-1:0]           carrier_q, carrier_d;
  logic [ARR_W-1:0]           envelope_q, envelope_d;
  logic [N_CHANNELS-1:0]      en_q, en_d;
  logic [SHIFT_WIDTH-1:0]     shift_q, shift_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic                       prod_vld_q, prod_vld_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0]       mixed_q, mixed_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;

  logic [IN_WIDTH-1:0]        car_sel;
  logic [IN_WIDTH-1:0]        env_sel;
  logic signed [PROD_W-1:0]   car_ext;
  logic signed [PROD_W-1:0]   env_ext;
  logic signed [PROD_W-1:0]   prod_shifted;
  logic signed [ACC_WIDTH-1:0] prod_acc_ext;
  logic [OUT_WIDTH-1:0]       reduced;
  logic                       accept;

  assign car_sel = carrier_q[idx_q*IN_WIDTH +: IN_WIDTH];
  assign env_sel = envelope_q[idx_q*IN_WIDTH +: IN_WIDTH];

  // Sign-extending both operands to the product width keeps the multiply exact and signed.
  assign car_ext = {{IN_WIDTH{car_sel[IN_WIDTH-1]}}, car_sel};
  assign env_ext = {{IN_WIDTH{env_sel[IN_WIDTH-1]}}, env_sel};

  assign prod_shifted = prod_q >>> shift_q;
  assign prod_acc_ext = {{(ACC_WIDTH-PROD_W){prod_shifted[PROD_W-1]}}, prod_shifted};

`ifdef VOCODER_MIX_SATURATE_EN
  sat_clamp #(
    .IN_W  (ACC_WIDTH),
    .OUT_W (OUT_WIDTH)
  ) u_sat_clamp (
    .in_dat  (acc_q),
    .out_dat (reduced)
  );
`else
  assign reduced = acc_q[OUT_WIDTH-1:0];
`endif

  assign accept = valid_in && ((state_q == IDLE) || (state_q == OUT));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carrier_d  = carrier_q;
    envelope_d = envelope_q;
    en_d       = en_q;
    shift_d    = shift_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    acc_d      = acc_q;
    mixed_d    = mixed_q;
    valid_d    = 1'b0;
    overrun_d  = valid_in && busy_q;

    if (prod_vld_q) begin
      acc_d = acc_q + prod_acc_ext;
    end

    case (state_q)
      IDLE, OUT: begin
        if (state_q == OUT) begin
          mixed_d = reduced;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        if (accept) begin
          carrier_d  = carrier_in;
          envelope_d = envelope_in;
          en_d       = channel_en_in;
          shift_d    = shift_in;
          acc_d      = '0;
          idx_d      = '0;
          state_d    = MAC;
        end
      end
      MAC: begin
        prod_d     = en_q[idx_q] ? car_ext * env_ext : '0;
        prod_vld_d = 1'b1;
        idx_d      = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == MAC) || (state_d == DRAIN);
  end

  always_ff @(posedge clk_in) begin
    if (!n_rst_in) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carrier_q  <= '0;
      envelope_q <= '0;
      en_q       <= '0;
      shift_q    <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      mixed_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carrier_q  <= carrier_d;
      envelope_q <= envelope_d;
      en_q       <= en_d;
      shift_q    <= shift_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      mixed_q    <= mixed_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign mixed_out   = mixed_q;
  assign valid_out   = valid_q;
  assign busy_out    = busy_q;
  assign overrun_out = overrun_q;

endmodule

// File: tb/tb_vocoder_mix_engine.sv
// Bench for vocoder_mix_engine (N=4, 32-bit in, 24-bit out) against a frame-level reference model.
module tb_vocoder_mix_engine;

  localparam int N  = 4;
  localparam int IW = 32;
  localparam int OW = 24;
  localparam int SW = 6;
  localparam int LAT = N + 2;

  logic            clk_in = 1'b0;
  logic            n_rst_in = 1'b0;
  logic            valid_in = 1'b0;
  logic [N*IW-1:0] carrier_in = '0;
  logic [N*IW-1:0] envelope_in = '0;
  logic [N-1:0]    channel_en_in = '0;
  logic [SW-1:0]   shift_in = '0;
  logic [OW-1:0]   mixed_out;
  logic            valid_out;
  logic            busy_out;
  logic            overrun_out;

  vocoder_mix_engine #(
    .N_CHANNELS  (N),
    .IN_WIDTH    (IW),
    .OUT_WIDTH   (OW),
    .SHIFT_WIDTH (SW)
  ) dut (
    .clk_in        (clk_in),
    .n_rst_in      (n_rst_in),
    .valid_in      (valid_in),
    .carrier_in    (carrier_in),
    .envelope_in   (envelope_in),
    .channel_en_in (channel_en_in),
    .shift_in      (shift_in),
    .mixed_out     (mixed_out),
    .valid_out     (valid_out),
    .busy_out      (busy_out),
    .overrun_out   (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is a sum of floor(c*e / 2^shift) over enabled channels,
  // published LAT edges after acceptance; a new frame is accepted from LAT edges on.
  typedef struct {
    int          t;
    logic [OW-1:0] v;
  } exp_t;

  exp_t          exp_q[$];
  int            free_at = 0;
  logic          exp_valid = 1'b0;
  logic          exp_busy = 1'b0;
  logic          exp_overrun = 1'b0;
  logic [OW-1:0] exp_mixed = '0;
  longint        m_sum;
  longint        m_prod;

  function automatic logic [OW-1:0] reduce_m(input longint s);
`ifdef VOCODER_MIX_SATURATE_EN
    if (s > 64'sd8388607) return 24'h7FFFFF;
    if (s < -64'sd8388608) return 24'h800000;
`endif
    return s[OW-1:0];
  endfunction

  always @(posedge clk_in) begin
    cyc++;
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
    if (!n_rst_in) begin
      exp_q.delete();
      exp_mixed = '0;
      free_at   = 0;
      exp_busy  = 1'b0;
    end else begin
      if (valid_in) begin
        if (cyc >= free_at) begin
          m_sum = 0;
          for (int k = 0; k < N; k++) begin
            if (channel_en_in[k]) begin
              m_prod = longint'($signed(carrier_in[k*IW +: IW])) *
                       longint'($signed(envelope_in[k*IW +: IW]));
              m_sum += m_prod >>> shift_in;
            end
          end
          exp_q.push_back('{t: cyc + LAT, v: reduce_m(m_sum)});
          free_at = cyc + LAT;
        end else begin
          exp_overrun = 1'b1;
        end
      end
      if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
        exp_mixed = exp_q[0].v;
        exp_valid = 1'b1;
        void'(exp_q.pop_front());
      end
      exp_busy = (cyc <= free_at - 2);
    end
  end

  always @(negedge clk_in) begin
    if (cyc > 0) begin
      check("valid_out", valid_out, exp_valid);
      check("mixed_out", mixed_out, exp_mixed);
      check("busy_out", busy_out, exp_busy);
      check("overrun_out", overrun_out, exp_overrun);
    end
  end

  int          c_arr[N];
  int          e_arr[N];
  logic [N-1:0] en_v = '1;
  logic [SW-1:0] sh_v = '0;

  task automatic set_all(input int c, input int e, input logic [N-1:0] en, input logic [SW-1:0] sh);
    for (int k = 0; k < N; k++) begin
      c_arr[k] = c;
      e_arr[k] = e;
    end
    en_v = en;
    sh_v = sh;
  endtask

  // Presents one cycle of inputs, sampled by the next edge; returns #1 after that edge.
  task automatic cyc_drive(input bit v);
    for (int k = 0; k < N; k++) begin
      carrier_in[k*IW +: IW]  = c_arr[k];
      envelope_in[k*IW +: IW] = e_arr[k];
    end
    channel_en_in = en_v;
    shift_in      = sh_v;
    valid_in      = v;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic run_frame(input string nm, input logic [OW-1:0] want);
    cyc_drive(1'b1);
    for (int i = 1; i < LAT; i++) cyc_drive(1'b0);
    check({nm, "_pre_valid"}, valid_out, 1'b0);
    cyc_drive(1'b0);
    check({nm, "_valid"}, valid_out, 1'b1);
    check({nm, "_mixed"}, mixed_out, want);
    cyc_drive(1'b0);
    check({nm, "_pulse_end"}, valid_out, 1'b0);
  endtask

  initial begin
    set_all(0, 0, '1, '0);
    n_rst_in = 1'b0;
    repeat (3) cyc_drive(1'b0);
    check("rst_mixed", mixed_out, 24'h0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_overrun", overrun_out, 1'b0);
    n_rst_in = 1'b1;
    cyc_drive(1'b0);

    set_all(1000, 2000, 4'b1111, 6'd0);
    run_frame("c1", 24'h7A1200);
    check("model_c1", exp_mixed, 24'h7A1200);

    set_all(100, -50, 4'b1111, 6'd4);
    run_frame("c2", 24'hFFFB1C);
    check("model_c2", exp_mixed, 24'hFFFB1C);

    set_all(1 << 20, 1 << 20, 4'b1111, 6'd0);
`ifdef VOCODER_MIX_SATURATE_EN
    run_frame("c3", 24'h7FFFFF);
`else
    run_frame("c3", 24'h000000);
`endif

    set_all(10, 10, 4'b0101, 6'd0);
    for (int k = 0; k < N; k++) c_arr[k] = k + 1;
    run_frame("c4a", 24'd40);
    en_v = 4'b0000;
    run_frame("c4b", 24'd0);

    // Drop a frame mid-flight, then accept back-to-back in the OUT cycle.
    set_all(1000, 2000, 4'b1111, 6'd0);
    cyc_drive(1'b1);
    cyc_drive(1'b0);
    set_all(7, 7, 4'b1111, 6'd0);
    cyc_drive(1'b1);
    check("c5_overrun", overrun_out, 1'b1);
    cyc_drive(1'b0);
    check("c5_overrun_end", overrun_out, 1'b0);
    cyc_drive(1'b0);
    cyc_drive(1'b0);
    set_all(3, -4, 4'b1111, 6'd1);
    cyc_drive(1'b1);
    check("c5_first_valid", valid_out, 1'b1);
    check("c5_first_mixed", mixed_out, 24'h7A1200);
    for (int i = 1; i < LAT; i++) cyc_drive(1'b0);
    check("c5_second_pre", valid_out, 1'b0);
    cyc_drive(1'b0);
    check("c5_second_valid", valid_out, 1'b1);
    check("c5_second_mixed", mixed_out, 24'hFFFFE8);
    cyc_drive(1'b0);

    // Reset three edges after acceptance aborts the frame.
    set_all(1000, 2000, 4'b1111, 6'd0);
    cyc_drive(1'b1);
    cyc_drive(1'b0);
    cyc_drive(1'b0);
    n_rst_in = 1'b0;
    cyc_drive(1'b0);
    n_rst_in = 1'b1;
    check("c6_mixed", mixed_out, 24'h0);
    check("c6_busy", busy_out, 1'b0);
    for (int i = 0; i < LAT; i++) begin
      cyc_drive(1'b0);
      check("c6_no_valid", valid_out, 1'b0);
    end
    run_frame("c6_after", 24'h7A1200);

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        c_arr[k] = int'($urandom_range(0, (1 << 29) - 1)) - (1 << 28);
        e_arr[k] = int'($urandom_range(0, (1 << 29) - 1)) - (1 << 28);
      end
      en_v     = N'($urandom());
      sh_v     = SW'($urandom_range(0, 40));
      n_rst_in = ($urandom_range(0, 99) >= 2);
      cyc_drive($urandom_range(0, 2) == 0);
    end
    n_rst_in = 1'b1;
    repeat (2 * LAT) cyc_drive(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
